// File: rtl/ee457_mdu_pkg.sv
// Shared encodings for the EE457 multiply/divide unit: op codes, FSM states
// and a small op-classification helper.
package ee457_mdu_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

  function automatic logic op_is_signed(op_e o);
    return (o == OP_MULT) || (o == OP_DIV);
  endfunction

endpackage

// File: rtl/ee457_mdu_divstep.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, subtract the divisor when it fits and emit one quotient bit.
module ee457_mdu_divstep #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rem,
  input  logic [DATA_W-1:0] quo,
  input  logic [DATA_W-1:0] dvs,
  output logic [DATA_W-1:0] rem_next,
  output logic [DATA_W-1:0] quo_next
);

  logic [DATA_W:0] shifted;
  logic            fits;

  assign shifted = {rem, quo[DATA_W-1]};
  assign fits    = (shifted >= {1'b0, dvs});

  // The true difference is below dvs, so DATA_W-bit wraparound is exact.
  assign rem_next = fits ? (shifted[DATA_W-1:0] - dvs) : shifted[DATA_W-1:0];
  assign quo_next = {quo[DATA_W-2:0], fits};

endmodule

// File: rtl/ee457_mdu.sv
// EE457 multiply/divide unit with HI/LO registers; sequential shift-add multiply
// and restoring divide. The divider is built only when EE457_MDU_DIV_EN is defined.
//
// state   | meaning
// IDLE    | waiting for start; MTHI/MTLO writes honoured
// CALC    | one multiply/divide bit per cycle, DATA_W cycles
// FIN     | sign correction, HI/LO write, done pulse
module ee457_mdu
  import ee457_mdu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] opa,
  input  logic [DATA_W-1:0] opb,
  input  logic              cancel,
  input  logic              hi_we,
  input  logic              lo_we,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic              dbz,
  output logic              op_err
);

  localparam int CNT_W = $clog2(DATA_W);

  state_e              state;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   acc;
  logic [DATA_W-1:0]   mpl;
  logic [DATA_W-1:0]   mcand;
  logic                is_div;
  logic                neg_q;

  logic                sgn_in;
  logic [DATA_W-1:0]   mag_a;
  logic [DATA_W-1:0]   mag_b;
  logic [DATA_W:0]     add_sum;
  logic [2*DATA_W-1:0] prod_fix;

  assign sgn_in   = op_is_signed(op_e'(op));
  assign mag_a    = (sgn_in && opa[DATA_W-1]) ? -opa : opa;
  assign mag_b    = (sgn_in && opb[DATA_W-1]) ? -opb : opb;
  assign add_sum  = {1'b0, acc} + (mpl[0] ? {1'b0, mcand} : '0);
  assign prod_fix = neg_q ? -{acc, mpl} : {acc, mpl};

`ifdef EE457_MDU_DIV_EN
  logic              neg_r;
  logic              dbz_pend;
  logic [DATA_W-1:0] div_rem;
  logic [DATA_W-1:0] div_quo;

  ee457_mdu_divstep #(.DATA_W(DATA_W)) u_divstep (
    .rem      (acc),
    .quo      (mpl),
    .dvs      (mcand),
    .rem_next (div_rem),
    .quo_next (div_quo)
  );
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      dbz      <= 1'b0;
      op_err   <= 1'b0;
      cnt      <= '0;
      acc      <= '0;
      mpl      <= '0;
      mcand    <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
`ifdef EE457_MDU_DIV_EN
      neg_r    <= 1'b0;
      dbz_pend <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start && !cancel) begin
            busy   <= 1'b1;
            dbz    <= 1'b0;
            op_err <= 1'b0;
            is_div <= op[1];
            neg_q  <= sgn_in & (opa[DATA_W-1] ^ opb[DATA_W-1]);
            cnt    <= CNT_W'(DATA_W - 1);
`ifdef EE457_MDU_DIV_EN
            neg_r    <= sgn_in & opa[DATA_W-1];
            dbz_pend <= 1'b0;
`endif
            if (!op[1]) begin
              mcand <= mag_a;
              acc   <= '0;
              mpl   <= mag_b;
              state <= ST_CALC;
            end else begin
`ifdef EE457_MDU_DIV_EN
              if (opb == '0) begin
                // Divide-by-zero result is staged now so FIN just copies it out.
                dbz_pend <= 1'b1;
                acc      <= opa;
                mpl      <= '1;
                state    <= ST_FIN;
              end else begin
                mcand <= mag_b;
                acc   <= '0;
                mpl   <= mag_a;
                state <= ST_CALC;
              end
`else
              state <= ST_FIN;
`endif
            end
          end else begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
          end
        end

        ST_CALC: begin
          if (cancel) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
`ifdef EE457_MDU_DIV_EN
            if (is_div) begin
              acc <= div_rem;
              mpl <= div_quo;
            end else begin
              acc <= add_sum[DATA_W:1];
              mpl <= {add_sum[0], mpl[DATA_W-1:1]};
            end
`else
            acc <= add_sum[DATA_W:1];
            mpl <= {add_sum[0], mpl[DATA_W-1:1]};
`endif
            if (cnt == '0) state <= ST_FIN;
            else           cnt   <= cnt - 1'b1;
          end
        end

        ST_FIN: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          if (!cancel) begin
            done <= 1'b1;
`ifdef EE457_MDU_DIV_EN
            if (dbz_pend) begin
              hi  <= acc;
              lo  <= mpl;
              dbz <= 1'b1;
            end else if (is_div) begin
              hi <= neg_r ? -acc : acc;
              lo <= neg_q ? -mpl : mpl;
            end else begin
              {hi, lo} <= prod_fix;
            end
`else
            if (is_div) op_err <= 1'b1;
            else        {hi, lo} <= prod_fix;
`endif
          end
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/ee457_mdu.md
EE457_MDU -- requirements
Module: ee457_mdu

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand/result width; legal values 8..64, even.
REQ-002 SHALL have port clk  input  1  single clock, rising-edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  input  1  request a new operation; sampled only in IDLE.
REQ-005 SHALL have port op  input  2  operation: MULT, MULTU, DIV, DIVU.
REQ-006 SHALL have port opa  input  DATA_W  multiplicand / dividend.
REQ-007 SHALL have port opb  input  DATA_W  multiplier / divisor.
REQ-008 SHALL have port cancel  input  1  abort the in-flight operation (pipeline flush).
REQ-009 SHALL have ports hi_we, lo_we  input  1 each  direct HI/LO write strobes (MTHI/MTLO).
REQ-010 SHALL have port wdata  input  DATA_W  data for hi_we/lo_we.
REQ-011 SHALL have port busy  output  1  high whenever state is not IDLE; CPU stalls on busy.
REQ-012 SHALL have port done  output  1  one-cycle pulse when HI/LO are updated by an operation.
REQ-013 SHALL have ports hi, lo  output  DATA_W each  registered HI/LO.
REQ-014 SHALL have port dbz  output  1  divide-by-zero flag, valid with done.
REQ-015 SHALL have port op_err  output  1  unsupported-op flag, valid with done.

Function
REQ-016 SHALL have states IDLE, CALC, FIN; IDLE->CALC on start&~cancel; CALC->FIN after DATA_W iterations; FIN->IDLE unconditionally.
REQ-017 SHALL, for MULT/MULTU, compute the 2*DATA_W product by radix-2 shift-add, one bit per cycle; hi = upper half, lo = lower half.
REQ-018 SHALL, for DIV/DIVU, compute by restoring division, one quotient bit per cycle; lo = quotient, hi = remainder.
REQ-019 SHALL, for signed ops, operate on magnitudes and apply sign correction in FIN: quotient truncates toward zero, remainder takes dividend sign.
REQ-020 SHALL give DIV of most-negative by -1 as lo = most-negative, hi = 0, dbz = 0.
REQ-021 SHALL latch op/opa/opb on the accepting edge; later input changes have no effect.
REQ-022 SHALL write hi/lo and pulse done on the FIN->IDLE edge: start accepted at edge 0 -> done high in the cycle after edge DATA_W+1.
REQ-023 SHALL, for DIV/DIVU with opb = 0, skip CALC (IDLE->FIN), set lo = all ones, hi = opa, dbz = 1.
REQ-024 SHALL ignore start while busy.
REQ-025 SHALL, on cancel in CALC or FIN, return to IDLE next edge with hi/lo unchanged and no done; cancel with start in IDLE wins (not accepted).
REQ-026 SHALL honour hi_we/lo_we only in IDLE and only when start is not being accepted; ignored while busy.
REQ-027 SHALL hold dbz/op_err until the next accepted start.

Reset
REQ-028 SHALL on rst force state IDLE, busy 0, done 0, hi 0, lo 0, dbz 0, op_err 0, immediately and independent of clk.
REQ-029 SHALL abort any in-flight operation on rst without updating hi/lo after release.

Configuration
REQ-030 SHALL compile the divider only when macro EE457_MDU_DIV_EN is defined.
REQ-031 SHALL, with EE457_MDU_DIV_EN undefined, accept DIV/DIVU, go IDLE->FIN, pulse done with op_err = 1, hi/lo unchanged, dbz = 0; multiply unaffected.

Structure
REQ-032 SHALL take op encodings (MULT 2'b00, MULTU 2'b01, DIV 2'b10, DIVU 2'b11) and state encodings from shared package ee457_mdu_pkg.
REQ-033 SHALL place the restoring-divide step datapath in sub-module ee457_mdu_divstep; multiply and control stay in ee457_mdu.

Verification (DATA_W = 32)
REQ-034 SHALL cover MULT opa=-3, opb=7 -> hi=FFFFFFFF, lo=FFFFFFEB, done in cycle after edge 33, busy high edges 0..33.
REQ-035 SHALL cover DIVU 100/7 -> lo=0000000E, hi=00000002; DIV -7/2 -> lo=FFFFFFFD, hi=FFFFFFFF.
REQ-036 SHALL cover DIV 5/0 -> lo=FFFFFFFF, hi=00000005, dbz=1, done after edge 1.
REQ-037 SHALL cover MULTU FFFFFFFF*FFFFFFFF -> hi=FFFFFFFE, lo=00000001; second start pulsed at cycle 10 ignored.
REQ-038 SHALL cover cancel at cycle 15 of a MULT -> IDLE next edge, hi/lo keep prior values, no done; then lo_we with wdata=1234 -> lo=00001234.
REQ-039 SHALL cover rst asserted mid-DIV -> busy/done/hi/lo 0 immediately; build without EE457_MDU_DIV_EN -> DIV gives op_err=1, hi/lo unchanged.
